// File: rtl/b06_eql_gen_if.sv
// b06_eql_gen_if: valid/ready word handshake into the b06 operand-compare stage.
// The master drives words, the slave (b06_eql_gen) accepts them.
interface b06_eql_gen_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/b06_eql_gen.sv
// b06_eql_gen: operand-compare and count stage for the b06 interrupt-handshake
// controller. Words arrive over a valid/ready handshake, are compared against a
// loadable reference, and the result is held on eql until acknowledged.
// A separate count-enable counter drives cont_eql.
// Optional feature macro: B06_EQL_CONT_WRAP_EN (counter wraps to 0 after the
// limit instead of saturating; cont_eql becomes a one-cycle pulse).
module b06_eql_gen #(
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 4,
    parameter int CONT_LIMIT = 9
) (
    input  logic                 clock,
    input  logic                 reset_n,
    b06_eql_gen_if.slave         in_if,
    input  logic                 ref_load,
    input  logic [DATA_W-1:0]    ref_data,
    input  logic                 enable_count,
    input  logic                 ackout,
    output logic                 eql,
    output logic                 cont_eql,
    output logic [CNT_W-1:0]     cnt_value
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(CONT_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q;
    logic                in_ready_q;
    logic                eql_q;
    logic [DATA_W-1:0]   ref_q,    ref_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                cont_eql_q, cont_eql_d;

    // Next-state for the reference, sample and count registers.
    always_comb begin
        ref_d      = ref_q;
        sample_d   = sample_q;
        cnt_d      = '0;
        cont_eql_d = 1'b0;

        if (ref_load) begin
            ref_d = ref_data;
        end

        if (state_q == IDLE && in_if.in_valid) begin
            sample_d = in_if.in_data;
        end

        // Any cycle with enable_count low clears the count; otherwise advance,
        // either sticking at the limit or wrapping past it.
        if (enable_count) begin
            if (cnt_q == LIMIT) begin
`ifdef B06_EQL_CONT_WRAP_EN
                cnt_d = '0;
`else
                cnt_d = LIMIT;
`endif
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Registered from the next count so cont_eql rises on the same edge
        // that the count reaches the limit.
        cont_eql_d = (cnt_d == LIMIT);
    end

    // Reference, sample and count registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ref_q      <= '0;
            sample_q   <= '0;
            cnt_q      <= '0;
            cont_eql_q <= 1'b0;
        end else begin
            ref_q      <= ref_d;
            sample_q   <= sample_d;
            cnt_q      <= cnt_d;
            cont_eql_q <= cont_eql_d;
        end
    end

    // Handshake FSM with registered in_ready and eql; eql is only ever high
    // while sitting in HOLD, so the controller always sees it drop in DRAIN.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            eql_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    eql_q <= 1'b0;
                    if (in_if.in_valid) begin
                        state_q    <= HOLD;
                        in_ready_q <= 1'b0;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                HOLD: begin
                    in_ready_q <= 1'b0;
                    if (ackout) begin
                        state_q <= DRAIN;
                        eql_q   <= 1'b0;
                    end else begin
                        // Compare against the reference held at the start of
                        // this cycle; a same-cycle ref_load shows next edge.
                        eql_q <= (sample_q == ref_q);
                    end
                end
                DRAIN: begin
                    eql_q <= 1'b0;
                    if (!ackout) begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                    end else begin
                        in_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                    eql_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign eql            = eql_q;
    assign cont_eql       = cont_eql_q;
    assign cnt_value      = cnt_q;

endmodule

// File: doc/b06_eql_gen.md
# b06_eql_gen

Operand-compare and count stage feeding the b06 interrupt-handshake controller. Accepts data words over a valid/ready handshake and compares each against a loadable reference word. Drives the controller's `EQL` and `CONT_EQL` inputs, and holds each result until the controller acknowledges it on `ACKOUT_REG`. Also owns the count-enable counter that the controller arms through `ENABLE_COUNT_REG`.

## Interface
- `DATA_W`, default 8: width of data and reference words.
- `CNT_W`, default 4: width of the count register.
- `CONT_LIMIT`, default 9: terminal count that asserts `cont_eql`. Must be ≥1 and ≤ 2^CNT_W−1.

Ports (the clock is named as elsewhere in the codebase; reset is asynchronous and active-low):
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream word present.
- `in_ready`  out  1  stage can accept a word.
- `in_data`  in  DATA_W  word to compare.
- `ref_load`  in  1  load `ref_data` into the reference register.
- `ref_data`  in  DATA_W  new reference value.
- `enable_count`  in  1  from `ENABLE_COUNT_REG`.
- `ackout`  in  1  from `ACKOUT_REG`; acknowledges the current result.
- `eql`  out  1  to `EQL`; registered compare result.
- `cont_eql`  out  1  to `CONT_EQL`; count has reached `CONT_LIMIT`.
- `cnt_value`  out  CNT_W  current count, for observation.

## Operation
- FSM states: IDLE, HOLD, DRAIN. Reset state is IDLE.
- **IDLE**
  - `in_ready`=1.
  - When `in_valid`=1, the word is latched into the sample register and the FSM moves to HOLD.
- **HOLD**
  - `in_ready`=0.
  - Every cycle, `eql` is registered as (sample == reference).
  - When `ackout`=1, the FSM moves to DRAIN.
- **DRAIN**
  - `in_ready`=0 and `eql` is forced to 0.
  - The FSM returns to IDLE on the first cycle with `ackout`=0.
  - This guarantees the controller sees `eql` low before the next word arrives.
- **Reference register**
  - Written on any cycle with `ref_load`=1, in any state.
  - A compare in HOLD uses the reference value registered at the start of that cycle.
- **Counter**
  - Increments each cycle that `enable_count`=1.
  - Saturates at `CONT_LIMIT`.
  - Synchronously clears to 0 on any cycle with `enable_count`=0.
- `cont_eql` is registered as (next count == `CONT_LIMIT`). It rises in the same edge on which the count reaches the limit.
- Reset mid-operation (any state): immediate return to IDLE, with all registers cleared and the sample discarded.

## Timing
- Reset values:
  - `in_ready`=1 (IDLE).
  - `eql`=0, `cont_eql`=0, `cnt_value`=0.
  - Reference=0, sample=0.
- Accept-to-`eql` latency: a word accepted at edge N gives a valid `eql` after edge N+1.
- A `ref_load` at edge N affects `eql` after edge N+1.
- Minimum word spacing: 4 cycles (IDLE, HOLD, one `ackout` cycle, DRAIN).
- `ackout` seen in IDLE: ignored.
- `ackout` already high on the HOLD entry edge: HOLD lasts exactly one cycle. The FSM then stays in DRAIN while `ackout` remains high.
- `cont_eql` is independent of the FSM. It follows `enable_count` only.
- `enable_count` drop while `cont_eql`=1: both `cont_eql` and the count clear on the next edge.

## Configuration
- `B06_EQL_CONT_WRAP_EN`
  - **Defined:** after reaching `CONT_LIMIT`, the counter wraps to 0 on the next enabled cycle. `cont_eql` is then a one-cycle pulse per `CONT_LIMIT`+1 enabled cycles.
  - **Undefined (default):** the counter saturates and `cont_eql` stays high until `enable_count` drops.

## Test plan
- Reset release, then `ref_load` with 0x5A, then `in_data`=0x5A with `in_valid` → `in_ready` falls and `eql`=1 one edge later. `ackout` pulse → `eql`=0 and return to IDLE with `in_ready`=1.
- `in_data`=0x33 against reference 0x5A → `eql` stays 0 in HOLD. `ref_load` with 0x33 while in HOLD → `eql`=1 one edge later.
- `enable_count` held high for 12 cycles with `CONT_LIMIT`=9 → `cnt_value` reaches 9 on the 9th edge, `cont_eql`=1 from that edge and held. Drop `enable_count` → both clear next edge. With `B06_EQL_CONT_WRAP_EN` defined: `cont_eql` is a pulse on the 9th edge and the count is 0 on the 10th.
- `ackout` held high across HOLD entry and for 3 further cycles → FSM remains in DRAIN with `eql`=0 and `in_ready`=0 until `ackout` falls, then `in_ready`=1.
- `reset_n` asserted asynchronously mid-HOLD with `eql`=1 and count=5 → `eql`, `cont_eql` and `cnt_value` read 0 immediately, without waiting for a clock edge, and `in_ready`=1. The reference reads back 0 on the next compare.
